yuv444to422_decimate: RTL and testbench

//  Inverse of the 422->444 unpacker. Packs a stream of Y'UV444 pixels back into packed Y'UV422.
//  - Consumes two 64-bit input beats (4 pixels) and produces one 64-bit output beat.
//  - Sits at the tail of the video stream chain, before the DMA writeback.
//  - Chroma is decimated per horizontal pixel pair: the even pixel's U/V is kept (or averaged, see CONFIGURATION).

---
 rtl/yuv444to422_decimate.sv | 205 ++++++++++++++++++++
 tb/tb_yuv444to422_decimate.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/yuv444to422_decimate.sv
// Packs Y'UV444 stream beats (2 pixels each) into Y'UV422 beats (4 pixels each).
// Define YUV444TO422_AVG_EN to average each pixel pair's chroma instead of keeping the even pixel's.
module yuv444to422_decimate #(
   parameter int DATA_WIDTH = 64,
   parameter int USER_WIDTH = 1,
   parameter int DEST_WIDTH = 1,
   parameter int CHAIN_ID   = 0
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    src_t_valid,
   output logic                    src_t_ready,
   input  logic [DATA_WIDTH-1:0]   src_t_data,
   input  logic [DATA_WIDTH/8-1:0] src_t_keep,
   input  logic [DATA_WIDTH/8-1:0] src_t_strb,
   input  logic                    src_t_last,
   input  logic [USER_WIDTH-1:0]   src_t_user,
   input  logic [DEST_WIDTH-1:0]   src_t_dest,
   output logic                    dst_t_valid,
   input  logic                    dst_t_ready,
   output logic [DATA_WIDTH-1:0]   dst_t_data,
   output logic [DATA_WIDTH/8-1:0] dst_t_keep,
   output logic [DATA_WIDTH/8-1:0] dst_t_strb,
   output logic                    dst_t_last,
   output logic [USER_WIDTH-1:0]   dst_t_user,
   output logic [DEST_WIDTH-1:0]   dst_t_dest
);

   localparam int KEEP_WIDTH = DATA_WIDTH / 8;
   localparam int BEAT_WIDTH = USER_WIDTH + 1 + DATA_WIDTH;

   typedef enum logic [1:0] {EVEN, ODD, FLUSH} state_t;

   state_t                  state_q, state_d;
   logic                    buf_valid_q, buf_valid_d;
   logic                    skid_valid_q, skid_valid_d;
   logic [BEAT_WIDTH-1:0]   buf_beat_q, buf_beat_d;
   logic [BEAT_WIDTH-1:0]   skid_beat_q, skid_beat_d;
   logic [BEAT_WIDTH-1:0]   src_beat;
   logic [DATA_WIDTH-1:0]   buf_data;
   logic                    buf_last;
   logic [USER_WIDTH-1:0]   buf_user;
   logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
   logic [USER_WIDTH-1:0]   hold_user_q, hold_user_d;
   logic                    dst_valid_q, dst_valid_d;
   logic [DATA_WIDTH-1:0]   dst_data_q, dst_data_d;
   logic [KEEP_WIDTH-1:0]   dst_keep_q, dst_keep_d;
   logic                    dst_last_q, dst_last_d;
   logic [USER_WIDTH-1:0]   dst_user_q, dst_user_d;
   logic [DEST_WIDTH-1:0]   dst_dest_q, dst_dest_d;
   logic                    fsm_ready, slot_free, load_pair, load_flush;
   logic                    src_acc, buf_acc;
   logic                    unused_dest;

   // One pixel pair -> {V01, Y1, U01, Y0}; byte3 of each pixel word is never read.
   function automatic logic [31:0] pack_pair(input logic [63:0] beat);
      logic [7:0] u01, v01;
`ifdef YUV444TO422_AVG_EN
      logic [8:0] u_sum, v_sum;
      u_sum = {1'b0, beat[15:8]} + {1'b0, beat[47:40]} + 9'd1;
      v_sum = {1'b0, beat[7:0]}  + {1'b0, beat[39:32]} + 9'd1;
      u01   = u_sum[8:1];
      v01   = v_sum[8:1];
`else
      u01   = beat[15:8];
      v01   = beat[7:0];
`endif
      return {v01, beat[55:48], u01, beat[23:16]};
   endfunction

   assign unused_dest = ^src_t_dest;
   assign src_beat    = {src_t_user, src_t_last, src_t_data};
   assign {buf_user, buf_last, buf_data} = buf_beat_q;

   // Input buffer with a skid slot so src_t_ready comes straight from a flop.
   assign src_t_ready = !skid_valid_q;
   assign src_acc     = src_t_valid && src_t_ready;
   assign buf_acc     = buf_valid_q && fsm_ready;

   always_comb begin
      buf_valid_d  = buf_valid_q;
      buf_beat_d   = buf_beat_q;
      skid_valid_d = skid_valid_q;
      skid_beat_d  = skid_beat_q;
      if (!buf_valid_q || buf_acc) begin
         if (skid_valid_q) begin
            buf_beat_d   = skid_beat_q;
            buf_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            buf_beat_d  = src_beat;
            buf_valid_d = src_acc;
         end
      end else if (src_acc) begin
         skid_beat_d  = src_beat;
         skid_valid_d = 1'b1;
      end
   end

   assign slot_free = !dst_valid_q || dst_t_ready;

   always_comb begin
      state_d     = state_q;
      fsm_ready   = 1'b0;
      load_pair   = 1'b0;
      load_flush  = 1'b0;
      hold_data_d = hold_data_q;
      hold_user_d = hold_user_q;
      case (state_q)
         EVEN: begin
            fsm_ready = 1'b1;
            if (buf_valid_q) begin
               hold_data_d = buf_data;
               hold_user_d = buf_user;
               state_d     = buf_last ? FLUSH : ODD;
            end
         end
         ODD: begin
            fsm_ready = slot_free;
            if (buf_valid_q && slot_free) begin
               load_pair = 1'b1;
               state_d   = EVEN;
            end
         end
         FLUSH: begin
            if (slot_free) begin
               load_flush = 1'b1;
               state_d    = EVEN;
            end
         end
         default: state_d = EVEN;
      endcase
   end

   always_comb begin
      dst_valid_d = dst_valid_q;
      dst_data_d  = dst_data_q;
      dst_keep_d  = dst_keep_q;
      dst_last_d  = dst_last_q;
      dst_user_d  = dst_user_q;
      dst_dest_d  = dst_dest_q;
      if (load_pair || load_flush) begin
         dst_valid_d = 1'b1;
         dst_user_d  = hold_user_q >> 1;
         dst_dest_d  = hold_user_q[0] ? DEST_WIDTH'(CHAIN_ID) : '0;
         if (load_pair) begin
            dst_data_d = {pack_pair(buf_data), pack_pair(hold_data_q)};
            dst_keep_d = '1;
            dst_last_d = buf_last;
         end else begin
            dst_data_d = {32'h0, pack_pair(hold_data_q)};
            dst_keep_d = 8'h0F;
            dst_last_d = 1'b1;
         end
      end else if (dst_t_ready) begin
         dst_valid_d = 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= EVEN;
         buf_valid_q  <= 1'b0;
         buf_beat_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_beat_q  <= '0;
         hold_data_q  <= '0;
         hold_user_q  <= '0;
         dst_valid_q  <= 1'b0;
         dst_data_q   <= '0;
         dst_keep_q   <= '1;
         dst_last_q   <= 1'b0;
         dst_user_q   <= '0;
         dst_dest_q   <= '0;
      end else begin
         state_q      <= state_d;
         buf_valid_q  <= buf_valid_d;
         buf_beat_q   <= buf_beat_d;
         skid_valid_q <= skid_valid_d;
         skid_beat_q  <= skid_beat_d;
         hold_data_q  <= hold_data_d;
         hold_user_q  <= hold_user_d;
         dst_valid_q  <= dst_valid_d;
         dst_data_q   <= dst_data_d;
         dst_keep_q   <= dst_keep_d;
         dst_last_q   <= dst_last_d;
         dst_user_q   <= dst_user_d;
         dst_dest_q   <= dst_dest_d;
      end
   end

   assign dst_t_valid = dst_valid_q;
   assign dst_t_data  = dst_data_q;
   assign dst_t_keep  = dst_keep_q;
   assign dst_t_strb  = dst_keep_q;
   assign dst_t_last  = dst_last_q;
   assign dst_t_user  = dst_user_q;
   assign dst_t_dest  = dst_dest_q;

   // Partial beats are still packed; the flag only alerts simulation.
   a_full_keep: assert property (@(posedge aclk) disable iff (!aresetn)
      (src_t_valid && src_t_ready) |-> (&src_t_keep && &src_t_strb))
      else $error("yuv444to422_decimate: input beat with partial t_keep/t_strb");

endmodule

// File: tb/tb_yuv444to422_decimate.sv
// Directed bench for yuv444to422_decimate: pairs, odd frames, backpressure, full rate, reset mid-pair.
// Expected values for the first-pair and lone-beat vectors follow YUV444TO422_AVG_EN.
module tb_yuv444to422_decimate;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        src_t_valid, src_t_ready, src_t_last;
   logic [63:0] src_t_data;
   logic [7:0]  src_t_keep, src_t_strb;
   logic [0:0]  src_t_user, src_t_dest;
   logic        dst_t_valid, dst_t_ready, dst_t_last;
   logic [63:0] dst_t_data;
   logic [7:0]  dst_t_keep, dst_t_strb;
   logic [0:0]  dst_t_user, dst_t_dest;

   always #5 aclk = ~aclk;

   yuv444to422_decimate #(
      .DATA_WIDTH(64), .USER_WIDTH(1), .DEST_WIDTH(1), .CHAIN_ID(1)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .src_t_valid(src_t_valid), .src_t_ready(src_t_ready), .src_t_data(src_t_data),
      .src_t_keep(src_t_keep), .src_t_strb(src_t_strb), .src_t_last(src_t_last),
      .src_t_user(src_t_user), .src_t_dest(src_t_dest),
      .dst_t_valid(dst_t_valid), .dst_t_ready(dst_t_ready), .dst_t_data(dst_t_data),
      .dst_t_keep(dst_t_keep), .dst_t_strb(dst_t_strb), .dst_t_last(dst_t_last),
      .dst_t_user(dst_t_user), .dst_t_dest(dst_t_dest)
   );

   localparam logic [63:0] B1 = 64'h002070E0_001080F0;
   localparam logic [63:0] B2 = 64'h004050C0_003060D0;
   localparam logic [63:0] BYTE3_JUNK = 64'h5A000000_C3000000;
`ifdef YUV444TO422_AVG_EN
   localparam logic [63:0] EXP_PAIR = 64'hC8405830_E8207810;
   localparam logic [63:0] EXP_LONE = 64'h00000000_E8207810;
`else
   localparam logic [63:0] EXP_PAIR = 64'hD0406030_F0208010;
   localparam logic [63:0] EXP_LONE = 64'h00000000_F0208010;
`endif

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        dest;
      logic [31:0] cyc;
   } beat_t;

   beat_t       out_q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic        stall_prev = 1'b0;
   logic [63:0] stall_data = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Output monitor: samples mid-cycle, records handshakes and checks stalled beats stay put.
   always @(negedge aclk) begin
      cyc++;
      #2;
      if (!aresetn) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid", 64'(dst_t_valid), 64'd1);
            check("stall_data", dst_t_data, stall_data);
         end
         if (dst_t_valid && dst_t_ready)
            out_q.push_back({dst_t_data, dst_t_keep, dst_t_last, dst_t_dest[0], 32'(cyc)});
         stall_prev = dst_t_valid && !dst_t_ready;
         stall_data = dst_t_data;
      end
   end

   // Called at a falling edge; returns at the falling edge after the beat is taken.
   task automatic send_beat(input logic [63:0] d, input logic last, input logic user);
      logic taken;
      taken       = 1'b0;
      src_t_valid = 1'b1;
      src_t_data  = d;
      src_t_last  = last;
      src_t_user  = user;
      for (int n = 0; n < 50 && !taken; n++) begin
         taken = src_t_ready;
         @(posedge aclk);
         @(negedge aclk);
      end
      check("src_accept", 64'(taken), 64'd1);
   endtask

   task automatic wait_out(input string tag, input int n);
      src_t_valid = 1'b0;
      for (int i = 0; i < 100 && out_q.size() < n; i++) begin
         @(negedge aclk);
         #3;
      end
      repeat (4) @(negedge aclk);
      #3;
      check({tag, "_count"}, 64'(out_q.size()), 64'(n));
      @(negedge aclk);
   endtask

   task automatic expect_beat(input string tag, input logic [63:0] d, input logic [7:0] k,
                              input logic l, output int c);
      beat_t b;
      c = 0;
      if (out_q.size() == 0) begin
         check({tag, "_present"}, 64'(out_q.size()), 64'd1);
         return;
      end
      b = out_q.pop_front();
      c = int'(b.cyc);
      check({tag, "_data"}, b.data, d);
      check({tag, "_keep"}, 64'(b.keep), 64'(k));
      check({tag, "_last"}, 64'(b.last), 64'(l));
   endtask

   initial begin
      logic [63:0] tab [8];
      logic [63:0] exp4 [4];
      int          c [4];
      int          cdummy;

      tab[0] = 64'h0001A0B0_0000A0B0;  tab[1] = 64'h0003A1B1_0002A1B1;
      tab[2] = 64'h0005A2B2_0004A2B2;  tab[3] = 64'h0007A3B3_0006A3B3;
      tab[4] = 64'h0009A4B4_0008A4B4;  tab[5] = 64'h000BA5B5_000AA5B5;
      tab[6] = 64'h000DA6B6_000CA6B6;  tab[7] = 64'h000FA7B7_000EA7B7;
      exp4[0] = 64'hB103A102_B001A000;  exp4[1] = 64'hB307A306_B205A204;
      exp4[2] = 64'hB50BA50A_B409A408;  exp4[3] = 64'hB70FA70E_B60DA60C;

      aresetn     = 1'b0;
      src_t_valid = 1'b0;
      src_t_data  = '0;
      src_t_keep  = 8'hFF;
      src_t_strb  = 8'hFF;
      src_t_last  = 1'b0;
      src_t_user  = 1'b0;
      src_t_dest  = 1'b0;
      dst_t_ready = 1'b1;
      repeat (3) @(negedge aclk);

      check("rst_valid", 64'(dst_t_valid), 64'd0);
      check("rst_data", dst_t_data, 64'd0);
      check("rst_keep", 64'(dst_t_keep), 64'hFF);
      check("rst_last", 64'(dst_t_last), 64'd0);
      check("rst_dest", 64'(dst_t_dest), 64'd0);
      check("rst_src_ready", 64'(src_t_ready), 64'd1);
      aresetn = 1'b1;
      @(negedge aclk);

      // Basic pair; first-beat t_user[0]=1 selects CHAIN_ID on t_dest.
      send_beat(B1, 1'b0, 1'b1);
      send_beat(B2, 1'b1, 1'b0);
      wait_out("pair", 1);
      check("pair_dest", 64'(out_q.size() > 0 ? out_q[0].dest : 1'b0), 64'd1);
      expect_beat("pair", EXP_PAIR, 8'hFF, 1'b1, cdummy);

      // Lone last beat is padded, then pairing restarts cleanly.
      send_beat(B1, 1'b1, 1'b0);
      wait_out("lone", 1);
      check("lone_dest", 64'(out_q.size() > 0 ? out_q[0].dest : 1'b1), 64'd0);
      expect_beat("lone", EXP_LONE, 8'h0F, 1'b1, cdummy);
      send_beat(B1, 1'b0, 1'b0);
      send_beat(B2, 1'b1, 1'b0);
      wait_out("restart", 1);
      expect_beat("restart", EXP_PAIR, 8'hFF, 1'b1, cdummy);

      // Backpressure: 5-cycle dst stall while 8 beats stream in.
      fork
         begin
            for (int k = 0; k < 8; k++) send_beat(tab[k] | BYTE3_JUNK, k == 7, 1'b0);
         end
         begin
            repeat (4) @(negedge aclk);
            dst_t_ready = 1'b0;
            repeat (5) @(negedge aclk);
            dst_t_ready = 1'b1;
         end
      join
      wait_out("bp", 4);
      for (int i = 0; i < 4; i++) expect_beat($sformatf("bp%0d", i), exp4[i], 8'hFF, i == 3, cdummy);

      // Full rate: one output every second cycle.
      for (int k = 0; k < 8; k++) send_beat(tab[k], k == 7, 1'b0);
      wait_out("rate", 4);
      for (int i = 0; i < 4; i++) expect_beat($sformatf("rate%0d", i), exp4[i], 8'hFF, i == 3, c[i]);
      for (int i = 1; i < 4; i++) check($sformatf("rate_gap%0d", i), 64'(c[i] - c[i-1]), 64'd2);

      // Reset with a stalled output beat and a half pair held.
      dst_t_ready = 1'b0;
      send_beat(B1, 1'b0, 1'b0);
      send_beat(B2, 1'b1, 1'b0);
      send_beat(tab[0], 1'b0, 1'b0);
      src_t_valid = 1'b0;
      repeat (2) @(negedge aclk);
      check("mid_pre_valid", 64'(dst_t_valid), 64'd1);
      aresetn = 1'b0;
      #1;
      check("mid_rst_valid", 64'(dst_t_valid), 64'd0);
      check("mid_rst_src_ready", 64'(src_t_ready), 64'd1);
      @(negedge aclk);
      aresetn     = 1'b1;
      dst_t_ready = 1'b1;
      out_q.delete();
      @(negedge aclk);
      send_beat(B1, 1'b0, 1'b1);
      send_beat(B2, 1'b1, 1'b0);
      wait_out("post_rst", 1);
      expect_beat("post_rst", EXP_PAIR, 8'hFF, 1'b1, cdummy);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
